music_sequencer: RTL and testbench

Autonomous melody sequencer that drives the music-feature stage. It steps through a small note table and generates the tone clock and tremolo clock that the feature stage consumes. Per note, it also drives the feature enables: octave down, octave up, tremolo and LED. It sits between the top-level pin wrapper (start/stop/loop controls) and the feature stage, so it is the only block that sequences that datapath.

---
 rtl/music_pkg.sv | 51 +++++
 rtl/melody_rom.sv | 26 ++
 rtl/music_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_music_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared constants for the melody sequencer: note-entry layout, flag bits,
// FSM state codes and the default melody table.
package music_pkg;

    localparam int FLAG_W        = 4;
    localparam int FLAG_OCT_DOWN = 0;
    localparam int FLAG_OCT_UP   = 1;
    localparam int FLAG_TREMOLO  = 2;
    localparam int FLAG_LED      = 3;

    localparam int DEF_NUM_NOTES = 16;
    localparam int DEF_DIV_W     = 12;
    localparam int DEF_DUR_W     = 8;
    localparam int DEF_ENTRY_W   = FLAG_W + DEF_DUR_W + DEF_DIV_W;

    // Entry layout, LSB first: div, then dur, then flags.
    localparam int DIV_OFS = 0;

    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    function automatic logic [DEF_ENTRY_W-1:0] mk_note(input logic [FLAG_W-1:0]    flags,
                                                       input logic [DEF_DUR_W-1:0] dur,
                                                       input logic [DEF_DIV_W-1:0] div);
        return {flags, dur, div};
    endfunction

    // Entry 15 first so that entry 0 lands in the low bits.
    localparam logic [DEF_NUM_NOTES*DEF_ENTRY_W-1:0] DEFAULT_MELODY = {
        mk_note(4'b1000, 8'd16, 12'd0),
        mk_note(4'b0000, 8'd8,  12'd956),
        mk_note(4'b0001, 8'd8,  12'd1073),
        mk_note(4'b0000, 8'd8,  12'd1204),
        mk_note(4'b0100, 8'd8,  12'd1276),
        mk_note(4'b0000, 8'd8,  12'd1432),
        mk_note(4'b0010, 8'd8,  12'd1607),
        mk_note(4'b1000, 8'd8,  12'd1804),
        mk_note(4'b0000, 8'd4,  12'd0),
        mk_note(4'b1100, 8'd8,  12'd1804),
        mk_note(4'b0000, 8'd8,  12'd1607),
        mk_note(4'b0000, 8'd8,  12'd1432),
        mk_note(4'b0100, 8'd8,  12'd1276),
        mk_note(4'b0000, 8'd8,  12'd1204),
        mk_note(4'b0010, 8'd8,  12'd1073),
        mk_note(4'b1000, 8'd8,  12'd956)
    };

endpackage

// File: rtl/melody_rom.sv
// Note table with one-cycle registered read, filled from the MELODY parameter.
module melody_rom
    import music_pkg::*;
#(
    parameter int NUM_NOTES = DEF_NUM_NOTES,
    parameter int ENTRY_W   = DEF_ENTRY_W,
    parameter logic [NUM_NOTES*ENTRY_W-1:0] MELODY = DEFAULT_MELODY
) (
    input  logic                         clk,
    input  logic [$clog2(NUM_NOTES)-1:0] addr,
    output logic [ENTRY_W-1:0]           data
);

    logic [ENTRY_W-1:0] rom_mem [NUM_NOTES];

    generate
        for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_entry
            assign rom_mem[gi] = MELODY[gi*ENTRY_W +: ENTRY_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        data <= rom_mem[addr];
    end

endmodule

// File: rtl/music_sequencer.sv
// Melody sequencer: walks the note table, generating tone and tremolo clocks
// plus per-note feature enables for the music-feature stage.
module music_sequencer
    import music_pkg::*;
#(
    parameter int NUM_NOTES  = DEF_NUM_NOTES,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int DUR_W      = DEF_DUR_W,
    parameter int TICK_DIV   = 1000,
    parameter int GAP_CYCLES = 64,
    parameter int TREM_DIV   = 4096,
    parameter logic [NUM_NOTES*(FLAG_W+DUR_W+DIV_W)-1:0] MELODY = DEFAULT_MELODY
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop_en,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_NOTES)-1:0] note_idx,
    output logic                         tone_clk,
    output logic                         trem_clk,
    output logic                         octave_dena,
    output logic                         octave_uena,
    output logic                         tremolo_ena,
    output logic                         led_ena
);

    localparam int ENTRY_W = FLAG_W + DUR_W + DIV_W;
    localparam int IDX_W   = $clog2(NUM_NOTES);
    localparam int TICK_W  = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TREM_W  = (TREM_DIV   > 1) ? $clog2(TREM_DIV)   : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_NOTES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TREM_W-1:0] TREM_LAST = TREM_W'(TREM_DIV - 1);

    state_t             state, state_next;
    logic [ENTRY_W-1:0] rom_data;
    logic [IDX_W-1:0]   rom_addr, next_idx;
    logic [DIV_W-1:0]   div_reg, tone_cnt;
    logic [DUR_W-1:0]   dur_reg, dur_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TREM_W-1:0]  trem_cnt;
    logic [FLAG_W-1:0]  rom_flags;
    logic [DUR_W-1:0]   rom_dur;
    logic               tick_last, play_last, gap_last, last_note, finish;

    assign busy      = (state != ST_IDLE);
    assign rom_flags = rom_data[DIV_W+DUR_W +: FLAG_W];
    assign rom_dur   = rom_data[DIV_W +: DUR_W];

    always_comb begin
        tick_last  = (tick_cnt == TICK_LAST);
        play_last  = tick_last && ((dur_cnt + DUR_W'(1)) == dur_reg);
        gap_last   = (gap_cnt == GAP_LAST);
        last_note  = (note_idx == IDX_LAST);
        next_idx   = last_note ? '0 : note_idx + IDX_W'(1);
        finish     = (state == ST_GAP) && gap_last && last_note && !loop_en && !stop;
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_PLAY;
            ST_PLAY: if (play_last) state_next = ST_GAP;
            ST_GAP:  if (gap_last) state_next = (last_note && !loop_en) ? ST_IDLE : ST_LOAD;
            default: state_next = ST_IDLE;
        endcase
        if (stop) state_next = ST_IDLE;
        // Address the entry about to be loaded so the data is ready during LOAD.
        rom_addr = (state == ST_GAP) ? next_idx : ((state == ST_IDLE) ? '0 : note_idx);
    end

    melody_rom #(
        .NUM_NOTES (NUM_NOTES),
        .ENTRY_W   (ENTRY_W),
        .MELODY    (MELODY)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            done        <= 1'b0;
            note_idx    <= '0;
            tone_clk    <= 1'b0;
            octave_dena <= 1'b0;
            octave_uena <= 1'b0;
            tremolo_ena <= 1'b0;
            led_ena     <= 1'b0;
            div_reg     <= '0;
            dur_reg     <= '0;
            tone_cnt    <= '0;
            dur_cnt     <= '0;
            tick_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (state_next == ST_IDLE) begin
                done        <= finish;
                note_idx    <= '0;
                tone_clk    <= 1'b0;
                octave_dena <= 1'b0;
                octave_uena <= 1'b0;
                tremolo_ena <= 1'b0;
                led_ena     <= 1'b0;
                tone_cnt    <= '0;
                dur_cnt     <= '0;
                tick_cnt    <= '0;
                gap_cnt     <= '0;
            end else begin
                case (state)
                    ST_IDLE: note_idx <= '0;
                    ST_LOAD: begin
                        div_reg     <= rom_data[DIV_OFS +: DIV_W];
                        dur_reg     <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                        tone_cnt    <= '0;
                        dur_cnt     <= '0;
                        tick_cnt    <= '0;
                        tone_clk    <= 1'b0;
                        octave_dena <= rom_flags[FLAG_OCT_DOWN];
                        // oct_down takes precedence when both octave flags are set.
                        octave_uena <= rom_flags[FLAG_OCT_UP] & ~rom_flags[FLAG_OCT_DOWN];
                        tremolo_ena <= rom_flags[FLAG_TREMOLO];
                        led_ena     <= rom_flags[FLAG_LED];
                    end
                    ST_PLAY: begin
                        if (div_reg != '0) begin
                            if (tone_cnt == div_reg - DIV_W'(1)) begin
                                tone_cnt <= '0;
                                tone_clk <= ~tone_clk;
                            end else begin
                                tone_cnt <= tone_cnt + DIV_W'(1);
                            end
                        end
                        if (tick_last) begin
                            tick_cnt <= '0;
                            dur_cnt  <= dur_cnt + DUR_W'(1);
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                        if (play_last) begin
                            tone_clk    <= 1'b0;
                            octave_dena <= 1'b0;
                            octave_uena <= 1'b0;
                            tremolo_ena <= 1'b0;
                            led_ena     <= 1'b0;
                            gap_cnt     <= '0;
                        end
                    end
                    ST_GAP: begin
                        if (gap_last) begin
                            note_idx <= next_idx;
                            gap_cnt  <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Tremolo divider runs only while busy and restarts from zero on every start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trem_cnt <= '0;
            trem_clk <= 1'b0;
        end else if (state == ST_IDLE || state_next == ST_IDLE) begin
            trem_cnt <= '0;
            trem_clk <= 1'b0;
        end else if (trem_cnt == TREM_LAST) begin
            trem_cnt <= '0;
            trem_clk <= ~trem_clk;
        end else begin
            trem_cnt <= trem_cnt + TREM_W'(1);
        end
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Randomized bench for music_sequencer: a per-cycle expected trace is built
// from the note table with plain arithmetic and compared against the outputs.
module tb_music_sequencer;

    localparam int NN    = 4;
    localparam int TICK  = 4;
    localparam int GAP   = 2;
    localparam int TREM  = 8;
    localparam int LIMIT = 400;

    // {flags, dur, div} per entry, entry 3 first.
    localparam logic [NN*24-1:0] TB_MELODY = {
        4'b1010, 8'd0, 12'd2,
        4'b1100, 8'd3, 12'd0,
        4'b0011, 8'd1, 12'd1,
        4'b0001, 8'd2, 12'd3
    };

    int n_div [NN] = '{3, 1, 0, 2};
    int n_dur [NN] = '{2, 1, 3, 0};
    int n_flg [NN] = '{1, 3, 12, 10};

    logic       clk, rst_n, start, stop, loop_en;
    logic       busy, done, tone_clk, trem_clk;
    logic       octave_dena, octave_uena, tremolo_ena, led_ena;
    logic [1:0] note_idx;

    music_sequencer #(
        .NUM_NOTES  (NN),
        .DIV_W      (12),
        .DUR_W      (8),
        .TICK_DIV   (TICK),
        .GAP_CYCLES (GAP),
        .TREM_DIV   (TREM),
        .MELODY     (TB_MELODY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .busy        (busy),
        .done        (done),
        .note_idx    (note_idx),
        .tone_clk    (tone_clk),
        .trem_clk    (trem_clk),
        .octave_dena (octave_dena),
        .octave_uena (octave_uena),
        .tremolo_ena (tremolo_ena),
        .led_ena     (led_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       busy;
        bit       done;
        bit       tone;
        bit [3:0] en;       // {led, tremolo, oct_up, oct_down}
        int       idx;
        bit       chk_idx;
        bit       chk_en;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   busy_n  = 0;
    int   done_seen, dena_note0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t rec(input bit b, input bit d, input bit t, input bit [3:0] en,
                                 input int idx, input bit ci, input bit ce);
        exp_t e;
        e.busy = b; e.done = d; e.tone = t; e.en = en;
        e.idx = idx; e.chk_idx = ci; e.chk_en = ce;
        return e;
    endfunction

    task automatic push_pass(input bit lp);
        for (int i = 0; i < NN; i++) begin
            int       p;
            bit [3:0] f, en;
            f  = 4'(n_flg[i]);
            en = {f[3], f[2], f[1] & ~f[0], f[0]};
            p  = ((n_dur[i] == 0) ? 1 : n_dur[i]) * TICK;
            exp_q.push_back(rec(1, 0, 0, 4'b0, i, 0, 0));
            for (int k = 0; k < p; k++)
                exp_q.push_back(rec(1, 0, (n_div[i] == 0) ? 1'b0 : 1'((k / n_div[i]) % 2), en, i, 1, 1));
            for (int g = 0; g < GAP; g++)
                exp_q.push_back(rec(1, 0, 0, 4'b0, i, 1, 1));
        end
        if (!lp) exp_q.push_back(rec(0, 1, 0, 4'b0, 0, 0, 1));
    endtask

    task automatic cycle();
        exp_t e;
        bit   trem_exp;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = rec(0, 0, 0, 4'b0, 0, 0, 1);
        if (e.busy) begin
            trem_exp = 1'((busy_n / TREM) % 2);
            busy_n++;
        end else begin
            trem_exp = 1'b0;
            busy_n   = 0;
        end
        if (done) done_seen++;
        if (octave_dena && busy && note_idx == 2'd0) dena_note0++;
        check_eq("busy", busy, e.busy);
        check_eq("done", done, e.done);
        check_eq("tone_clk", tone_clk, e.tone);
        check_eq("trem_clk", trem_clk, trem_exp);
        if (e.chk_en) check_eq("enables", {led_ena, tremolo_ena, octave_uena, octave_dena}, e.en);
        if (e.chk_idx) check_eq("note_idx", note_idx, e.idx);
    endtask

    // One start-to-idle run; stop_at < 0 means no stop, otherwise stop is
    // raised during busy cycle number stop_at.
    task automatic run(input bit lp, input int stop_at, input bit rnd_start);
        int k;
        done_seen  = 0;
        dena_note0 = 0;
        loop_en    = lp;
        start      = 1'b1;
        push_pass(lp);
        cycle();
        start = 1'b0;
        k     = 0;
        while (exp_q.size() > 0 && k < LIMIT) begin
            if (lp && exp_q.size() < 8) push_pass(1);
            if (k == stop_at) begin
                stop = 1'b1;
                exp_q.delete();
            end else if (rnd_start && exp_q[0].busy && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
            end
            cycle();
            start = 1'b0;
            stop  = 1'b0;
            k++;
        end
        check_eq("run_bound", k < LIMIT, 1);
        check_eq("done_count", done_seen, (!lp && stop_at < 0) ? 1 : 0);
        $display("[TB] run loop=%0d stop_at=%0d cycles=%0d done=%0d", lp, stop_at, k + 1, done_seen);
        repeat ($urandom_range(1, 4)) cycle();
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_note_idx", note_idx, 0);
        check_eq("rst_outputs", {done, tone_clk, trem_clk, led_ena, tremolo_ena, octave_uena, octave_dena}, 0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Single pass: note 0 has oct_down for 8 PLAY cycles, one done pulse.
        run(0, -1, 0);
        check_eq("dena_note0_cycles", dena_note0, 2 * TICK);

        run(0, -1, 1);
        run(1, $urandom_range(40, 75), 1);
        run(0, $urandom_range(19, 30), 0);

        // start and stop together from idle: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) cycle();
        $display("[TB] start+stop from idle, busy=%0d", busy);

        // Asynchronous reset in the middle of note 1 PLAY.
        loop_en = 1'b0;
        start   = 1'b1;
        push_pass(0);
        cycle();
        start = 1'b0;
        repeat (12) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_note_idx", note_idx, 0);
        check_eq("async_rst_outputs", {done, tone_clk, trem_clk, led_ena, tremolo_ena, octave_uena, octave_dena}, 0);
        exp_q.delete();
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        $display("[TB] async reset mid-play, busy=%0d", busy);

        for (int r = 0; r < 4; r++) begin
            bit lp;
            int sa;
            lp = 1'($urandom_range(0, 1));
            if (lp) sa = $urandom_range(30, 90);
            else    sa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 39) : -1;
            run(lp, sa, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
